// File: rtl/ddr3_bram_responder_if.sv
// ============================================================================
// Module  : ddr3_bram_responder_if
// Brief   : DRAM user-side command / write-data / read-data bundle between the
//           ORAM core (master) and the DRAM controller or its BRAM stand-in.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface ddr3_bram_responder_if #(
    parameter int DDRCWidth = 3,
    parameter int DDRAWidth = 28,
    parameter int DDRDWidth = 512,
    parameter int DDRMWidth = 64
);
    logic [DDRCWidth-1:0] DRAMCommand;
    logic [DDRAWidth-1:0] DRAMAddress;
    logic                 DRAMCommandValid;
    logic                 DRAMCommandReady;
    logic [DDRDWidth-1:0] DRAMWriteData;
    logic [DDRMWidth-1:0] DRAMWriteMask;
    logic                 DRAMWriteDataValid;
    logic                 DRAMWriteDataReady;
    logic [DDRDWidth-1:0] DRAMReadData;
    logic                 DRAMReadDataValid;

    modport master (
        output DRAMCommand, DRAMAddress, DRAMCommandValid,
        output DRAMWriteData, DRAMWriteMask, DRAMWriteDataValid,
        input  DRAMCommandReady, DRAMWriteDataReady,
        input  DRAMReadData, DRAMReadDataValid
    );

    modport slave (
        input  DRAMCommand, DRAMAddress, DRAMCommandValid,
        input  DRAMWriteData, DRAMWriteMask, DRAMWriteDataValid,
        output DRAMCommandReady, DRAMWriteDataReady,
        output DRAMReadData, DRAMReadDataValid
    );
endinterface

`default_nettype wire

// File: rtl/ddr3_bram_responder.sv
// ============================================================================
// Module  : ddr3_bram_responder
// Brief   : BRAM-backed cycle-level stand-in for the MIG7 DDR3 user interface.
//           Optional macro DRAM_RESPONDER_STALL_EN adds LFSR command stalls.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module ddr3_bram_responder #(
    parameter int DDRCWidth   = 3,
    parameter int DDRAWidth   = 28,
    parameter int DDRDWidth   = 512,
    parameter int DDRMWidth   = 64,
    parameter int MemDepthLog = 10,
    parameter int ReadLatency = 4,
    parameter int WDQDepthLog = 2
) (
    input  wire                        Clock,
    input  wire                        Reset,
    ddr3_bram_responder_if.slave       bus,
    output logic                       InitDone,
    output logic                       ErrorIllegalCmd
);
    localparam logic [DDRCWidth-1:0] c_CMD_WRITE = '0;
    localparam logic [DDRCWidth-1:0] c_CMD_READ  = DDRCWidth'(1);
    localparam int                   c_MEM_DEPTH = 1 << MemDepthLog;
    localparam int                   c_WDQ_DEPTH = 1 << WDQDepthLog;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [MemDepthLog-1:0]   r_init_cnt;
    logic                     r_init_done;
    logic                     w_init_last;
    logic [MemDepthLog-1:0]   w_idx;
    logic                     w_stall;
    logic                     w_cmd_ready;
    logic                     w_wr_fire;
    logic                     w_rd_fire;
    logic                     w_ill_fire;
    logic                     w_wd_ready;
    logic                     w_push;
    logic                     w_wq_empty;
    logic                     w_wq_full;
    logic [WDQDepthLog:0]     r_wq_wr;
    logic [WDQDepthLog:0]     r_wq_rd;
    logic [DDRDWidth-1:0]     r_wq_data [c_WDQ_DEPTH];
    logic [DDRMWidth-1:0]     r_wq_mask [c_WDQ_DEPTH];
    logic [DDRDWidth-1:0]     w_head_data;
    logic [DDRMWidth-1:0]     w_head_mask;
    logic [DDRDWidth-1:0]     r_mem [c_MEM_DEPTH];
    logic [DDRDWidth-1:0]     r_rd_data [ReadLatency];
    logic [ReadLatency-1:0]   r_rd_vld;
    logic                     r_err;
    logic                     w_unused_addr;

    assign w_init_last   = (r_init_cnt == {MemDepthLog{1'b1}});
    assign w_idx         = bus.DRAMAddress[MemDepthLog+2:3];
    assign w_unused_addr = &{1'b0, bus.DRAMAddress[DDRAWidth-1:MemDepthLog+3],
                             bus.DRAMAddress[2:0]};

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) r_state <= ST_INIT;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: if (w_init_last) w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
        end else if (r_state == ST_INIT) begin
            r_init_cnt <= r_init_cnt + MemDepthLog'(1);
            if (w_init_last) r_init_done <= 1'b1;
        end
    end

`ifdef DRAM_RESPONDER_STALL_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)                  r_lfsr <= 16'hACE1;
        else if (r_state == ST_RUN) r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
    end

    assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
    assign w_stall = 1'b0;
`endif

    // Write FIFO occupancy is judged on start-of-cycle pointers, so a burst
    // pushed this cycle cannot satisfy a write command in the same cycle.
    assign w_wq_empty = (r_wq_wr == r_wq_rd);
    assign w_wq_full  = ((r_wq_wr - r_wq_rd) == (WDQDepthLog+1)'(c_WDQ_DEPTH));
    assign w_head_data = r_wq_data[r_wq_rd[WDQDepthLog-1:0]];
    assign w_head_mask = r_wq_mask[r_wq_rd[WDQDepthLog-1:0]];

    assign w_cmd_ready = (r_state == ST_RUN) && !w_stall &&
                         ((bus.DRAMCommand != c_CMD_WRITE) || !w_wq_empty);
    assign w_wr_fire   = bus.DRAMCommandValid && w_cmd_ready && (bus.DRAMCommand == c_CMD_WRITE);
    assign w_rd_fire   = bus.DRAMCommandValid && w_cmd_ready && (bus.DRAMCommand == c_CMD_READ);
    assign w_ill_fire  = bus.DRAMCommandValid && w_cmd_ready &&
                         (bus.DRAMCommand != c_CMD_WRITE) && (bus.DRAMCommand != c_CMD_READ);
    assign w_wd_ready  = (r_state == ST_RUN) && !w_wq_full;
    assign w_push      = bus.DRAMWriteDataValid && w_wd_ready;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_wq_wr <= '0;
            r_wq_rd <= '0;
        end else begin
            if (w_push)    r_wq_wr <= r_wq_wr + (WDQDepthLog+1)'(1);
            if (w_wr_fire) r_wq_rd <= r_wq_rd + (WDQDepthLog+1)'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (w_push) begin
            r_wq_data[r_wq_wr[WDQDepthLog-1:0]] <= bus.DRAMWriteData;
            r_wq_mask[r_wq_wr[WDQDepthLog-1:0]] <= bus.DRAMWriteMask;
        end
    end

    // Mask bit set means the byte keeps its old contents.
    always_ff @(posedge Clock) begin
        if (r_state == ST_INIT) begin
            r_mem[r_init_cnt] <= '0;
        end else if (w_wr_fire) begin
            for (int b = 0; b < DDRMWidth; b++) begin
                if (!w_head_mask[b]) r_mem[w_idx][b*8 +: 8] <= w_head_data[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < ReadLatency; i++) r_rd_data[i] <= '0;
            r_rd_vld <= '0;
        end else begin
            r_rd_vld[0] <= w_rd_fire;
            if (w_rd_fire) r_rd_data[0] <= r_mem[w_idx];
            for (int i = 1; i < ReadLatency; i++) begin
                r_rd_vld[i]  <= r_rd_vld[i-1];
                r_rd_data[i] <= r_rd_data[i-1];
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)           r_err <= 1'b0;
        else if (w_ill_fire) r_err <= 1'b1;
    end

    assign bus.DRAMCommandReady   = w_cmd_ready;
    assign bus.DRAMWriteDataReady = w_wd_ready;
    assign bus.DRAMReadData       = r_rd_data[ReadLatency-1];
    assign bus.DRAMReadDataValid  = r_rd_vld[ReadLatency-1];
    assign InitDone               = r_init_done;
    assign ErrorIllegalCmd        = r_err;

endmodule

`default_nettype wire

// File: doc/ddr3_bram_responder.md
Name: ddr3_bram_responder

Overview:
- Cycle-level stand-in for the MIG7 DDR3 controller; answers the DRAM-side command/data interface that the ORAM core drives.
- Backed by on-chip block RAM so the ORAM core can be simulated and run on the board without DDR3 calibration.
- Drop-in for the DRAM controller instance: same user-side ports, no DDR3 pins.

Parameters:
DDRCWidth, 3, command width; 3'b000 = write, 3'b001 = read
DDRAWidth, 28, address width in 64-bit column units
DDRDWidth, 512, data burst width (one burst = 8 columns)
DDRMWidth, 64, byte write-mask width (DDRDWidth/8)
MemDepthLog, 10, log2 of number of 512-bit bursts stored
ReadLatency, 4, cycles from read-command acceptance to DRAMReadDataValid, >= 1
WDQDepthLog, 2, log2 of write-data FIFO depth

Ports:
Clock  in  1  sole clock
Reset  in  1  asynchronous, active-high reset
DRAMCommand  in  DDRCWidth  command code
DRAMAddress  in  DDRAWidth  column address; bits [2:0] ignored
DRAMCommandValid  in  1  command valid
DRAMCommandReady  out  1  command accepted when Valid & Ready
DRAMWriteData  in  DDRDWidth  write burst
DRAMWriteMask  in  DDRMWidth  1 = byte NOT written
DRAMWriteDataValid  in  1  write burst valid
DRAMWriteDataReady  out  1  write FIFO not full
DRAMReadData  out  DDRDWidth  read burst
DRAMReadDataValid  out  1  read burst valid; no backpressure
InitDone  out  1  memory clear finished
ErrorIllegalCmd  out  1  sticky; set on accepted command other than read/write

Behaviour:
- Reset values: DRAMCommandReady=0, DRAMWriteDataReady=0, DRAMReadDataValid=0, DRAMReadData=0, InitDone=0, ErrorIllegalCmd=0; FIFO pointers and read pipeline valids cleared.
- FSM states:
  - INIT: a counter sweeps indices 0..2^MemDepthLog-1, writing zero at one index per cycle; both Ready outputs low. On terminal count, go to RUN and assert InitDone the next cycle.
  - RUN: steady state; no exit except Reset.
- Reset asserted mid-operation aborts any in-flight reads (their valids are dropped) and discards FIFO contents. INIT restarts and re-zeroes memory.
- Index: DRAMAddress[MemDepthLog+2:3]. Upper address bits are ignored, so addresses wrap modulo 2^MemDepthLog bursts.
- Write-data FIFO: depth 2^WDQDepthLog; push on DRAMWriteDataValid & DRAMWriteDataReady. Data may arrive before, with, or after its command; bursts pair with write commands in FIFO order.
- DRAMCommandReady in RUN:
  - high for read or illegal commands;
  - for a write, high only if the FIFO is non-empty at the start of the cycle (same-cycle push does not count).
- Accepted write: pop the FIFO head and commit it to memory that cycle, per byte where the mask bit = 0.
- Accepted read: issue the BRAM read. Data and valid travel through a ReadLatency-stage pipeline; fully pipelined, one read per cycle.
- Ordering: a read accepted the cycle after a write to the same index returns the new data. Read data is returned in command order.
- Illegal command: accepted, no memory effect, ErrorIllegalCmd set until Reset.
- FIFO full: DRAMWriteDataReady=0; a push attempt while full is ignored by handshake. Simultaneous push and pop when full is not allowed, since Ready is evaluated before the pop.

Optional Feature:
- Macro DRAM_RESPONDER_STALL_EN.
- Defined: a 16-bit LFSR (seed 16'hACE1, advances every cycle in RUN) forces DRAMCommandReady low whenever its low 2 bits = 2'b00. This yields roughly 25% pseudo-random command stalls to exercise ORAM backpressure. Read latency is unchanged.
- Undefined: no LFSR logic; Ready follows the rules above.

Test Plan:
- Reset, hold Valid low -> Ready=0 for exactly 2^MemDepthLog cycles (1024 by default); InitDone rises 1 cycle after the sweep ends; a read to address 0 then returns 512'h0.
- Push burst 512'hA5..A5 with mask 0, then write command at address 28'h40 -> accepted the next cycle; read at 28'h40 -> DRAMReadDataValid exactly 4 cycles after acceptance with A5..A5.
- Write 512'hFF..FF mask 0 at 28'h8, then 512'h0 with mask 64'hFFFF_FFFF_FFFF_FFFE at 28'h8; read -> byte0=8'h00, all other bytes 8'hFF.
- Write command with FIFO empty held 10 cycles -> Ready=0 throughout; push data -> command accepted the following cycle.
- Fill FIFO with 4 bursts and no commands -> DRAMWriteDataReady=0; issue 4 write commands to 0x00,0x08,0x10,0x18, then back-to-back reads -> 4 consecutive valid cycles returning the data in push order.
- Command 3'b010 -> ErrorIllegalCmd=1 and persists. Assert Reset while 2 reads are in flight -> no read valids emerge, ErrorIllegalCmd=0, INIT restarts.
